// File: rtl/conv_config_loader_if.sv
// Config word stream into the conv configuration loader: {addr, data} words
// moved on a vld/rdy handshake.
interface conv_config_loader_if #(
  parameter int CONFIG_ADDR_WIDTH = 8,
  parameter int CONFIG_DATA_WIDTH = 8
);
  logic [CONFIG_ADDR_WIDTH+CONFIG_DATA_WIDTH-1:0] config_data;
  logic                                           config_vld;
  logic                                           config_rdy;

  modport master (output config_data, output config_vld, input  config_rdy);
  modport slave  (input  config_data, input  config_vld, output config_rdy);
endinterface

// File: rtl/conv_config_loader.sv
// Assembles the layer-shape registers from a byte-addressed config stream and
// holds them frozen with config_enable high until the layer reports done.
module conv_config_loader #(
  parameter int CONFIG_ADDR_WIDTH     = 8,
  parameter int CONFIG_DATA_WIDTH     = 8,
  parameter int BANK_ADDR_WIDTH       = 13,
  parameter int OFMAP_BANK_ADDR_WIDTH = 8,
  parameter int COUNTER_WIDTH         = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  conv_config_loader_if.slave              cfg,
  input  logic                             layer_done,
  output logic                             config_enable,
  output logic                             config_err,
  output logic [BANK_ADDR_WIDTH-1:0]       weight_max_adr,
  output logic [BANK_ADDR_WIDTH-1:0]       ifmap_max_wadr,
  output logic [OFMAP_BANK_ADDR_WIDTH-1:0] ofmap_max_adr,
  output logic [BANK_ADDR_WIDTH-1:0]       OX0,
  output logic [BANK_ADDR_WIDTH-1:0]       OY0,
  output logic [BANK_ADDR_WIDTH-1:0]       FX,
  output logic [BANK_ADDR_WIDTH-1:0]       FY,
  output logic [BANK_ADDR_WIDTH-1:0]       STRIDE,
  output logic [BANK_ADDR_WIDTH-1:0]       IX0,
  output logic [BANK_ADDR_WIDTH-1:0]       IY0,
  output logic [BANK_ADDR_WIDTH-1:0]       IC1,
  output logic [COUNTER_WIDTH-1:0]         OC1,
  output logic [COUNTER_WIDTH-1:0]         IC1_FY_FX_OY0_OX0,
  output logic [COUNTER_WIDTH-1:0]         OY0_OX0
);

  localparam int NUM_BYTES   = 34;
  localparam int COMMIT_ADDR = 34;
  localparam int NUM_PAIRS   = 8;

  typedef enum logic {CFG, RUN} state_e;

  state_e                        state_q;
  logic                          rdy_q;
  logic                          en_q;
  logic                          err_q;
  logic [NUM_BYTES-1:0]          mask_q;
  logic [NUM_BYTES-1:0]          wr_en;
  logic [NUM_BYTES-1:0][7:0]     byte_q;
  logic [NUM_PAIRS-1:0][BANK_ADDR_WIDTH-1:0] pair_fld;

  logic [CONFIG_ADDR_WIDTH-1:0]  cfg_addr;
  logic [7:0]                    cfg_byte;
  logic                          accept;
  logic                          commit;
  logic                          addr_bad;

  assign cfg_addr = cfg.config_data[CONFIG_ADDR_WIDTH+CONFIG_DATA_WIDTH-1 -: CONFIG_ADDR_WIDTH];
  assign cfg_byte = cfg.config_data[7:0];
  assign accept   = rdy_q && cfg.config_vld && (state_q == CFG);
  assign commit   = accept && (cfg_addr == CONFIG_ADDR_WIDTH'(COMMIT_ADDR));
  assign addr_bad = accept && (cfg_addr >  CONFIG_ADDR_WIDTH'(COMMIT_ADDR));

  // One byte register per config address; fields are sliced out below, so
  // bits past a field's width simply never reach an output.
  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_byte
    assign wr_en[k] = accept && (cfg_addr == CONFIG_ADDR_WIDTH'(k));

    always_ff @(posedge clk) begin
      if (!rst_n)        byte_q[k] <= '0;
      else if (wr_en[k]) byte_q[k] <= cfg_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CFG;
      rdy_q   <= 1'b0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      mask_q  <= '0;
    end else begin
      case (state_q)
        CFG: begin
          rdy_q  <= 1'b1;
          mask_q <= mask_q | wr_en;
          if (addr_bad) err_q <= 1'b1;
          if (commit) begin
            // Incomplete commit keeps the mask so the host can patch and retry.
            if (&mask_q) begin
              state_q <= RUN;
              en_q    <= 1'b1;
              rdy_q   <= 1'b0;
            end else begin
              err_q   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (layer_done) begin
            state_q <= CFG;
            en_q    <= 1'b0;
            rdy_q   <= 1'b1;
            mask_q  <= '0;
          end
        end
        default: state_q <= CFG;
      endcase
    end
  end

  assign cfg.config_rdy = rdy_q;
  assign config_enable  = en_q;
  assign config_err     = err_q;

  // Byte pairs 6/7 .. 20/21 map onto the eight shape fields in port order.
  for (genvar f = 0; f < NUM_PAIRS; f++) begin : g_pair
    assign pair_fld[f] = BANK_ADDR_WIDTH'({byte_q[7+2*f], byte_q[6+2*f]});
  end

  assign weight_max_adr    = BANK_ADDR_WIDTH'({byte_q[1], byte_q[0]});
  assign ifmap_max_wadr    = BANK_ADDR_WIDTH'({byte_q[3], byte_q[2]});
  assign ofmap_max_adr     = OFMAP_BANK_ADDR_WIDTH'({byte_q[5], byte_q[4]});
  assign OX0               = pair_fld[0];
  assign OY0               = pair_fld[1];
  assign FX                = pair_fld[2];
  assign FY                = pair_fld[3];
  assign STRIDE            = pair_fld[4];
  assign IX0               = pair_fld[5];
  assign IY0               = pair_fld[6];
  assign IC1               = pair_fld[7];
  assign OC1               = COUNTER_WIDTH'({byte_q[25], byte_q[24], byte_q[23], byte_q[22]});
  assign IC1_FY_FX_OY0_OX0 = COUNTER_WIDTH'({byte_q[29], byte_q[28], byte_q[27], byte_q[26]});
  assign OY0_OX0           = COUNTER_WIDTH'({byte_q[33], byte_q[32], byte_q[31], byte_q[30]});

endmodule

// File: tb/tb_conv_config_loader.sv
// Directed bench for conv_config_loader: full layer load, RUN freeze,
// reconfigure, incomplete commit, bad address, reset mid-layer, byte packing.
module tb_conv_config_loader;
  localparam int AW = 8, DW = 8, BW = 13, OW = 8, CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          layer_done = 1'b0;
  logic          config_enable, config_err;
  logic [BW-1:0] weight_max_adr, ifmap_max_wadr;
  logic [OW-1:0] ofmap_max_adr;
  logic [BW-1:0] OX0, OY0, FX, FY, STRIDE, IX0, IY0, IC1;
  logic [CW-1:0] OC1, IC1_FY_FX_OY0_OX0, OY0_OX0;

  conv_config_loader_if #(.CONFIG_ADDR_WIDTH(AW), .CONFIG_DATA_WIDTH(DW)) cif ();

  conv_config_loader #(
    .CONFIG_ADDR_WIDTH(AW), .CONFIG_DATA_WIDTH(DW), .BANK_ADDR_WIDTH(BW),
    .OFMAP_BANK_ADDR_WIDTH(OW), .COUNTER_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cif.slave), .layer_done(layer_done),
    .config_enable(config_enable), .config_err(config_err),
    .weight_max_adr(weight_max_adr), .ifmap_max_wadr(ifmap_max_wadr),
    .ofmap_max_adr(ofmap_max_adr), .OX0(OX0), .OY0(OY0), .FX(FX), .FY(FY),
    .STRIDE(STRIDE), .IX0(IX0), .IY0(IY0), .IC1(IC1), .OC1(OC1),
    .IC1_FY_FX_OY0_OX0(IC1_FY_FX_OY0_OX0), .OY0_OX0(OY0_OX0)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] lay [34];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  // Present one word from a negedge once rdy is seen; returns 1ns after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] d);
    int w = 0;
    @(negedge clk);
    while (!cif.config_rdy && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cif.config_rdy) begin
      chk("rdy_wait", cif.config_rdy, 1);
      cif.config_vld = 1'b0;
      return;
    end
    cif.config_data = {a, d};
    cif.config_vld  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    cif.config_vld = 1'b0;
  endtask

  task automatic load(input int skip);
    for (int a = 0; a < 34; a++)
      if (a != skip) send(8'(a), lay[a]);
  endtask

  task automatic done_pulse();
    @(negedge clk);
    cif.config_vld = 1'b0;
    layer_done     = 1'b1;
    @(negedge clk);
    layer_done     = 1'b0;
  endtask

  initial begin
    // weight 143 (18*IC0-1, IC0=8), ifmap 72, ofmap 31, OX0=OY0=4, FX=FY=3,
    // STRIDE 1, IX0=IY0=6, IC1 2, OC1 2, IC1*FY*FX*OY0*OX0 = 288, OY0*OX0 = 16
    for (int a = 0; a < 34; a++) lay[a] = 8'h00;
    lay[0] = 8'h8F; lay[2] = 8'd72; lay[4] = 8'd31;
    lay[6] = 8'd4;  lay[8] = 8'd4;  lay[10] = 8'd3; lay[12] = 8'd3;
    lay[14] = 8'd1; lay[16] = 8'd6; lay[18] = 8'd6; lay[20] = 8'd2;
    lay[22] = 8'd2; lay[26] = 8'h20; lay[27] = 8'h01; lay[30] = 8'd16;

    cif.config_vld  = 1'b0;
    cif.config_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", cif.config_rdy, 0);
    chk("rst_en", config_enable, 0);
    chk("rst_err", config_err, 0);
    chk("rst_wmax", weight_max_adr, 0);
    chk("rst_oc1", OC1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", cif.config_rdy, 1);

    // First layer, back-to-back words then commit
    load(-1);
    send(8'd34, 8'h00);
    chk("a_en", config_enable, 1);
    chk("a_rdy", cif.config_rdy, 0);
    chk("a_err", config_err, 0);
    chk("a_ix0", IX0, 6);
    chk("a_iy0", IY0, 6);
    chk("a_oy0ox0", OY0_OX0, 16);
    chk("a_icff", IC1_FY_FX_OY0_OX0, 288);
    chk("a_wmax", weight_max_adr, 143);
    chk("a_ifmap", ifmap_max_wadr, 72);
    chk("a_ofmap", ofmap_max_adr, 31);
    chk("a_fx", FX, 3);
    chk("a_stride", STRIDE, 1);
    chk("a_oc1", OC1, 2);

    // vld held high during RUN must be ignored
    @(negedge clk);
    cif.config_data = {8'd0, 8'h55};
    cif.config_vld  = 1'b1;
    repeat (4) @(negedge clk);
    chk("hold_rdy", cif.config_rdy, 0);
    chk("hold_en", config_enable, 1);
    chk("hold_wmax", weight_max_adr, 143);
    chk("hold_fx", FX, 3);
    done_pulse();
    chk("done_rdy", cif.config_rdy, 1);
    chk("done_en", config_enable, 0);

    // Reconfigure: only FX changes
    lay[10] = 8'd5;
    load(-1);
    send(8'd34, 8'h00);
    chk("re_en", config_enable, 1);
    chk("re_fx", FX, 5);
    chk("re_fy", FY, 3);
    chk("re_ox0", OX0, 4);
    chk("re_ix0", IX0, 6);
    chk("re_oc1", OC1, 2);
    chk("re_icff", IC1_FY_FX_OY0_OX0, 288);
    chk("re_wmax", weight_max_adr, 143);
    chk("re_err", config_err, 0);
    done_pulse();

    // Commit with address 17 missing, then patch and recommit
    load(17);
    send(8'd34, 8'h00);
    chk("miss_err", config_err, 1);
    chk("miss_en", config_enable, 0);
    idle();
    chk("miss_rdy", cif.config_rdy, 1);
    send(8'd17, lay[17]);
    send(8'd34, 8'h00);
    chk("fix_en", config_enable, 1);
    chk("fix_err", config_err, 1);

    // Reset while RUN
    @(negedge clk);
    cif.config_vld = 1'b0;
    rst_n          = 1'b0;
    @(negedge clk);
    chk("mr_en", config_enable, 0);
    chk("mr_err", config_err, 0);
    chk("mr_fx", FX, 0);
    chk("mr_wmax", weight_max_adr, 0);
    chk("mr_oc1", OC1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_rdy", cif.config_rdy, 1);

    // Wide field little-endian packing and truncation of byte 1
    send(8'd22, 8'h78);
    send(8'd23, 8'h56);
    send(8'd24, 8'h34);
    send(8'd25, 8'h12);
    idle();
    chk("pack_oc1", OC1, 32'h12345678);
    send(8'd1, 8'hFF);
    idle();
    chk("pack_whi", weight_max_adr[12:8], 5'h1F);
    chk("pack_w", weight_max_adr, 13'h1F00);
    chk("pre_bad_err", config_err, 0);

    // Out-of-range address: consumed, flags error, changes nothing
    send(8'h40, 8'hAA);
    idle();
    chk("bad_err", config_err, 1);
    chk("bad_rdy", cif.config_rdy, 1);
    chk("bad_en", config_enable, 0);
    chk("bad_oc1", OC1, 32'h12345678);
    chk("bad_w", weight_max_adr, 13'h1F00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
